// File: rtl/charge_session_if.sv
// Front-panel inputs and display-path outputs of the charge session controller.
interface charge_session_if;
  logic       power_sw;
  logic       coin_1;
  logic       coin_5;
  logic       confirm;
  logic       cancel;
  logic       tick;
  logic [3:0] money_1;
  logic [3:0] money_2;
  logic [3:0] time_1;
  logic [3:0] time_2;
  logic [2:0] current_state;
  logic       no_display;
  logic       LT;
  logic       RBI;
  logic       BI;
  logic       coin_reject;

  modport master (
    output power_sw, coin_1, coin_5, confirm, cancel, tick,
    input  money_1, money_2, time_1, time_2, current_state,
           no_display, LT, RBI, BI, coin_reject
  );

  modport slave (
    input  power_sw, coin_1, coin_5, confirm, cancel, tick,
    output money_1, money_2, time_1, time_2, current_state,
           no_display, LT, RBI, BI, coin_reject
  );
endinterface

// File: rtl/charge_session_ctrl.sv
// Session controller for the coin-operated charger: coin entry, countdown, display control.
// Optional lamp-test state after power-on is built when LAMP_TEST_EN is defined.
module charge_session_ctrl #(
  parameter int unsigned MAX_MONEY     = 20,
  parameter int unsigned TIME_PER_UNIT = 2,
  parameter int unsigned IDLE_TIMEOUT  = 10,
  parameter int unsigned DONE_TICKS    = 5,
  parameter int unsigned LT_TICKS      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  charge_session_if.slave   bus
);

  localparam int unsigned VAL_W   = 7;
  localparam int unsigned MAX_AB  = (IDLE_TIMEOUT > DONE_TICKS) ? IDLE_TIMEOUT : DONE_TICKS;
  localparam int unsigned CNT_MAX = (MAX_AB > LT_TICKS) ? MAX_AB : LT_TICKS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READY  = 3'd1,
    S_INPUT  = 3'd2,
    S_CHARGE = 3'd3,
    S_DONE   = 3'd4
`ifdef LAMP_TEST_EN
    , S_LAMP = 3'd5
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         m1_q, m2_q, t1_q, t2_q;
  logic [3:0]         m1_d, m2_d, t1_d, t2_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               reject_q, reject_d;
  logic               no_display_q, no_display_d;
  logic               bi_q, bi_d;
  logic               lt_q, lt_d;

  logic [VAL_W-1:0]   money_v, time_v, money_sum, time_sum;
  logic [VAL_W-1:0]   money_v_d, time_v_d;
  logic [2:0]         coin_sum;
  logic               coin_any, coin_over, idle_expired;

  // Arithmetic is done on binary values, then split back into BCD digits
  assign money_v   = VAL_W'(m1_q) * VAL_W'(10) + VAL_W'(m2_q);
  assign time_v    = VAL_W'(t1_q) * VAL_W'(10) + VAL_W'(t2_q);
  assign coin_sum  = (bus.coin_1 ? 3'd1 : 3'd0) + (bus.coin_5 ? 3'd5 : 3'd0);
  assign coin_any  = bus.coin_1 | bus.coin_5;
  assign money_sum = money_v + VAL_W'(coin_sum);
  assign time_sum  = time_v + VAL_W'(32'(coin_sum) * TIME_PER_UNIT);
  assign coin_over = 32'(money_sum) > MAX_MONEY;
  assign idle_expired = (32'(cnt_q) + 32'd1) >= IDLE_TIMEOUT;

  always_comb begin
    state_d   = state_q;
    money_v_d = money_v;
    time_v_d  = time_v;
    cnt_d     = cnt_q;
    reject_d  = 1'b0;

    if (!bus.power_sw) begin
      state_d   = S_IDLE;
      money_v_d = '0;
      time_v_d  = '0;
      cnt_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          money_v_d = '0;
          time_v_d  = '0;
          cnt_d     = '0;
`ifdef LAMP_TEST_EN
          state_d   = S_LAMP;
`else
          state_d   = S_READY;
`endif
        end
`ifdef LAMP_TEST_EN
        S_LAMP: begin
          if (bus.tick) begin
            if ((32'(cnt_q) + 32'd1) >= LT_TICKS) begin
              state_d = S_READY;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
`endif
        S_READY: begin
          if (!bus.cancel && !bus.confirm && coin_any) begin
            if (coin_over) begin
              reject_d = 1'b1;
            end else begin
              state_d   = S_INPUT;
              money_v_d = money_sum;
              time_v_d  = time_sum;
              cnt_d     = '0;
            end
          end
        end
        S_INPUT: begin
          if (bus.cancel) begin
            state_d   = S_READY;
            money_v_d = '0;
            time_v_d  = '0;
            cnt_d     = '0;
          end else if (bus.confirm) begin
            cnt_d = '0;
            if (money_v != '0) state_d = S_CHARGE;
          end else if (coin_any) begin
            cnt_d = '0;
            if (coin_over) begin
              reject_d = 1'b1;
            end else begin
              money_v_d = money_sum;
              time_v_d  = time_sum;
            end
          end else if (bus.tick) begin
            if (idle_expired) begin
              state_d   = S_READY;
              money_v_d = '0;
              time_v_d  = '0;
              cnt_d     = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_CHARGE: begin
          if (bus.cancel) begin
            state_d   = S_DONE;
            money_v_d = '0;
            time_v_d  = '0;
            cnt_d     = '0;
          end else begin
            reject_d = coin_any;
            if (bus.tick) begin
              if (time_v <= VAL_W'(1)) begin
                state_d   = S_DONE;
                money_v_d = '0;
                time_v_d  = '0;
                cnt_d     = '0;
              end else begin
                time_v_d = time_v - VAL_W'(1);
              end
            end
          end
        end
        S_DONE: begin
          money_v_d = '0;
          time_v_d  = '0;
          if (bus.tick) begin
            if ((32'(cnt_q) + 32'd1) >= DONE_TICKS) begin
              state_d = S_READY;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d   = S_IDLE;
          money_v_d = '0;
          time_v_d  = '0;
          cnt_d     = '0;
        end
      endcase
    end

    m1_d = 4'(money_v_d / VAL_W'(10));
    m2_d = 4'(money_v_d % VAL_W'(10));
    t1_d = 4'(time_v_d / VAL_W'(10));
    t2_d = 4'(time_v_d % VAL_W'(10));

    // Decoder controls follow the state being entered so they stay in step with the digits
    no_display_d = (state_d == S_IDLE);
    bi_d         = (state_d != S_IDLE);
`ifdef LAMP_TEST_EN
    lt_d         = (state_d != S_LAMP);
`else
    lt_d         = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      m1_q         <= '0;
      m2_q         <= '0;
      t1_q         <= '0;
      t2_q         <= '0;
      cnt_q        <= '0;
      reject_q     <= 1'b0;
      no_display_q <= 1'b1;
      bi_q         <= 1'b0;
      lt_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      m1_q         <= m1_d;
      m2_q         <= m2_d;
      t1_q         <= t1_d;
      t2_q         <= t2_d;
      cnt_q        <= cnt_d;
      reject_q     <= reject_d;
      no_display_q <= no_display_d;
      bi_q         <= bi_d;
      lt_q         <= lt_d;
    end
  end

  assign bus.money_1       = m1_q;
  assign bus.money_2       = m2_q;
  assign bus.time_1        = t1_q;
  assign bus.time_2        = t2_q;
  assign bus.current_state = state_q;
  assign bus.no_display    = no_display_q;
  assign bus.BI            = bi_q;
  assign bus.LT            = lt_q;
  assign bus.RBI           = 1'b1;
  assign bus.coin_reject   = reject_q;

endmodule

// File: tb/tb_charge_session_ctrl.sv
// Directed bench for charge_session_ctrl; set LAMP_TEST_EN to exercise the lamp-test path.
module tb_charge_session_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  charge_session_if bus();

  charge_session_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_dig(input string tag, input int m, input int t);
    chk({tag, ".money_1"}, 8'(bus.money_1), 8'(m / 10));
    chk({tag, ".money_2"}, 8'(bus.money_2), 8'(m % 10));
    chk({tag, ".time_1"},  8'(bus.time_1),  8'(t / 10));
    chk({tag, ".time_2"},  8'(bus.time_2),  8'(t % 10));
  endtask

  task automatic chk_st(input string tag, input int s);
    chk(tag, 8'(bus.current_state), 8'(s));
  endtask

  // Apply one cycle of pulse inputs, then sample just after the capturing edge
  task automatic drv(input logic c1, input logic c5, input logic cf, input logic cn, input logic tk);
    bus.coin_1 = c1; bus.coin_5 = c5; bus.confirm = cf; bus.cancel = cn; bus.tick = tk;
    @(posedge clk); #1;
    bus.coin_1 = 1'b0; bus.coin_5 = 1'b0; bus.confirm = 1'b0; bus.cancel = 1'b0; bus.tick = 1'b0;
  endtask

  task automatic coin1();   drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic coin5();   drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic confirm(); drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); endtask
  task automatic cancel();  drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); endtask
  task automatic tick();    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); endtask
  task automatic idle();    drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); endtask

  task automatic power_on();
    bus.power_sw = 1'b1;
    idle();
`ifdef LAMP_TEST_EN
    chk_st("lamp_state", 5);
    chk("lamp_LT", 8'(bus.LT), 8'd0);
    chk("lamp_BI", 8'(bus.BI), 8'd1);
    coin5();
    chk_st("lamp_coin_state", 5);
    chk_dig("lamp_coin", 0, 0);
    chk("lamp_coin_reject", 8'(bus.coin_reject), 8'd0);
    tick(); tick();
    chk_st("lamp_2ticks", 5);
    tick();
`endif
    chk_st("ready_state", 1);
    chk("ready_no_display", 8'(bus.no_display), 8'd0);
    chk("ready_BI", 8'(bus.BI), 8'd1);
    chk("ready_LT", 8'(bus.LT), 8'd1);
    chk_dig("ready", 0, 0);
  endtask

  initial begin
    bus.power_sw = 1'b0;
    bus.coin_1 = 1'b0; bus.coin_5 = 1'b0; bus.confirm = 1'b0; bus.cancel = 1'b0; bus.tick = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_st("rst_state", 0);
    chk("rst_no_display", 8'(bus.no_display), 8'd1);
    chk("rst_BI", 8'(bus.BI), 8'd0);
    chk("rst_LT", 8'(bus.LT), 8'd1);
    chk("rst_RBI", 8'(bus.RBI), 8'd1);
    chk("rst_reject", 8'(bus.coin_reject), 8'd0);
    chk_dig("rst", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Power-on
    power_on();
    chk("RBI_held", 8'(bus.RBI), 8'd1);

    // Coin entry 5+5+1, full charge countdown
    coin5();
    chk_st("c5_state", 2);
    chk_dig("c5", 5, 10);
    coin5();
    coin1();
    chk_dig("c11", 11, 22);
    confirm();
    chk_st("charge_state", 3);
    for (int i = 1; i <= 21; i++) begin
      tick();
      chk_dig("countdown", 11, 22 - i);
    end
    chk_st("charge_at_01", 3);
    tick();
    chk_st("done_state", 4);
    chk_dig("done", 0, 0);
    repeat (4) tick();
    chk_st("done_4ticks", 4);
    tick();
    chk_st("done_to_ready", 1);

    // Over-limit reject at 18, then boundary at 20
    coin5(); coin5(); coin5(); coin1(); coin1(); coin1();
    chk_dig("m18", 18, 36);
    coin5();
    chk("reject_pulse", 8'(bus.coin_reject), 8'd1);
    chk_dig("reject_hold", 18, 36);
    chk_st("reject_state", 2);
    idle();
    chk("reject_clear", 8'(bus.coin_reject), 8'd0);
    cancel();
    chk_st("cancel_input", 1);
    chk_dig("cancel_input", 0, 0);
    coin5(); coin5(); coin1(); coin1(); coin1(); coin1();
    chk_dig("m14", 14, 28);
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_dig("dual_coin", 20, 40);
    chk("dual_no_reject", 8'(bus.coin_reject), 8'd0);
    coin1();
    chk("at_max_reject", 8'(bus.coin_reject), 8'd1);
    chk_dig("at_max_hold", 20, 40);
    cancel();

    // Inactivity timeout
    coin1(); coin1(); coin1();
    chk_dig("m3", 3, 6);
    repeat (9) tick();
    chk_st("idle_9ticks", 2);
    tick();
    chk_st("idle_timeout", 1);
    chk_dig("idle_timeout", 0, 0);

    // Coin coincident with tick 9 restarts the inactivity count
    coin1(); coin1(); coin1();
    repeat (8) tick();
    drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_dig("coin_tick9", 4, 8);
    tick();
    chk_st("after_tick10", 2);
    repeat (8) tick();
    chk_st("restart_9ticks", 2);
    tick();
    chk_st("restart_timeout", 1);

    // Power-off mid charge at time 15
    coin5(); coin1(); coin1(); coin1();
    confirm();
    tick();
    chk_dig("t15", 8, 15);
    coin1();
    chk("charge_coin_reject", 8'(bus.coin_reject), 8'd1);
    chk_dig("charge_coin_hold", 8, 15);
    bus.power_sw = 1'b0;
    idle();
    chk_st("poweroff_state", 0);
    chk("poweroff_no_display", 8'(bus.no_display), 8'd1);
    chk("poweroff_BI", 8'(bus.BI), 8'd0);
    chk_dig("poweroff", 0, 0);

    // Cancel during charge
    power_on();
    coin5();
    confirm();
    tick();
    chk_dig("t9", 5, 9);
    cancel();
    chk_st("cancel_charge", 4);
    chk_dig("cancel_charge", 0, 0);
    repeat (5) tick();
    chk_st("cancel_done_ready", 1);

    // Confirm with no money is ignored
    confirm();
    chk_st("confirm_ready", 1);

    // Asynchronous reset mid-session
    coin5();
    chk_st("pre_reset", 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_st("async_rst_state", 0);
    chk_dig("async_rst", 0, 0);
    chk("async_rst_no_display", 8'(bus.no_display), 8'd1);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/charge_session_ctrl.md
Name: charge_session_ctrl

Overview:
- Top-level session controller for the coin-operated charger.
- Sequences the user session (power-on, coin entry, confirm, charge countdown, done) and produces all BCD digits, state code and decoder configuration consumed by the display scanning path.
- Sits between debounced front-panel inputs and the display scanner.
- All outputs are registered and drive the scanner directly.

Parameters:
MAX_MONEY, 20, money ceiling in yuan; must satisfy MAX_MONEY*TIME_PER_UNIT <= 99
TIME_PER_UNIT, 2, charge time units granted per yuan
IDLE_TIMEOUT, 10, ticks of inactivity in INPUT before the session is abandoned
DONE_TICKS, 5, ticks spent in DONE before returning to READY
LT_TICKS, 3, lamp-test duration in ticks (used only with LAMP_TEST_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
power_sw  in  1  level; 1 = charger switched on
coin_1  in  1  one-cycle pulse; 1-yuan coin inserted
coin_5  in  1  one-cycle pulse; 5-yuan coin inserted
confirm  in  1  one-cycle pulse; start charging
cancel  in  1  one-cycle pulse; abort entry or charge
tick  in  1  one-cycle pulse per time unit (1 Hz enable)
money_1  out  4  money tens digit, BCD
money_2  out  4  money units digit, BCD
time_1  out  4  time tens digit, BCD
time_2  out  4  time units digit, BCD
current_state  out  3  state code
no_display  out  1  1 = blank all tubes and lights
LT  out  1  lamp test to decoder, active-low
RBI  out  1  ripple-blank input to decoder, held 1
BI  out  1  blanking input to decoder, active-low
coin_reject  out  1  one-cycle pulse; coin refused

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE, all digits 0, no_display=1, BI=0, LT=1, RBI=1, coin_reject=0, all counters 0.
- Money and time are held as BCD digit pairs. Increments and decrements carry/borrow between digits. Outputs never show a non-BCD value.
- All outputs are registered: an event in cycle N is visible in cycle N+1.
- Input priority each cycle: power_sw=0 > cancel > confirm > coins > tick.
- States (current_state code):
  - IDLE 000: no_display=1, BI=0. Goes to READY when power_sw=1 (to LAMP if the macro is enabled).
  - READY 001: digits show 00/00, no_display=0, BI=1. Any accepted coin goes to INPUT and applies that coin.
  - INPUT 010:
    - Coins add to money; time adds coin*TIME_PER_UNIT.
    - confirm with money>0 goes to CHARGE. confirm with money=0 is ignored.
    - cancel clears money/time and goes to READY.
    - The inactivity counter increments on tick and is cleared by any coin or confirm. On reaching IDLE_TIMEOUT: clear money/time, go to READY. A tick coincident with an event does not count.
  - CHARGE 011:
    - Coins are ignored (coin_reject pulses). Money display is held.
    - Each tick decrements time by 1. The tick that makes time 00 moves to DONE.
    - cancel clears time and goes to DONE.
  - DONE 100: digits forced to 00/00. Counts DONE_TICKS ticks, then goes to READY.
- Coin acceptance:
  - coin_1 and coin_5 in the same cycle are summed (6) and applied as one event.
  - If money + sum > MAX_MONEY, the whole event is rejected: no change, coin_reject=1 for one cycle, inactivity counter still cleared.
  - In IDLE, DONE and LAMP, coins are dropped silently (no reject).
- power_sw=0 in any state: next cycle is IDLE with all values cleared. This aborts a charge without passing through DONE.
- rst_n asserted mid-session: immediate return to reset values. No state survives.

Optional Feature:
LAMP_TEST_EN:
- Enabled: IDLE with power_sw=1 goes to LAMP (code 101). LAMP drives LT=0, BI=1, no_display=0 for LT_TICKS ticks, then goes to READY. Coins, confirm and cancel are ignored in LAMP; power_sw=0 still returns to IDLE.
- Disabled: LAMP state does not exist, LT is constant 1, and IDLE goes directly to READY.

Test Plan:
- Reset, then power_sw=1 -> state 001, digits 0000, no_display=0, BI=0→1 one cycle after power_sw.
- coin_5, coin_5, coin_1 -> state 010, money 1/1, time 2/2; confirm -> 011; 22 ticks -> time counts 21..00, DONE on 22nd tick; after 5 further ticks -> 001.
- Money 18, then coin_5 -> coin_reject one cycle, money stays 1/8; then coin_1 and coin_5 same cycle at money 14 -> money 2/0, time 4/0.
- INPUT with money 3, 10 ticks without events -> state 001, digits 0000; a repeat run with coin_1 at tick 9 -> still 010 after tick 10.
- Charging at time 15, power_sw=0 -> next cycle 000, no_display=1, all digits 0; cancel during charge -> 100, time 00.
- With LAMP_TEST_EN: power_sw=1 -> 101 with LT=0 for 3 ticks, then 001 with LT=1; coin_5 during LAMP has no effect.
